// File: rtl/ctx_mem_pkg.sv
// Shared definitions for the context memory command path: command encoding,
// field positions and the scheduler state encoding.
package ctx_mem_pkg;

  localparam logic [7:0] CMD_IDLE = 8'h80;
  localparam int WE_N_BIT = 7;
  localparam int WOP_MSB  = 6;
  localparam int WOP_LSB  = 3;
  localparam int ROP_MSB  = 2;
  localparam int BANK_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  // Write burst: we_n low, write_op = {1, 0, bank}, read_op idle.
  function automatic logic [7:0] wr_cmd(input logic [BANK_W-1:0] bank);
    logic [7:0] c;
    c = CMD_IDLE;
    c[WE_N_BIT] = 1'b0;
    c[WOP_MSB] = 1'b1;
    c[WOP_LSB +: BANK_W] = bank;
    return c;
  endfunction

  // Read burst: we_n high, write_op idle, read_op = {0, bank}.
  function automatic logic [7:0] rd_cmd(input logic [BANK_W-1:0] bank);
    logic [7:0] c;
    c = CMD_IDLE;
    c[ROP_MSB] = 1'b0;
    c[ROP_MSB-1 -: BANK_W] = bank;
    return c;
  endfunction

endpackage

// File: rtl/context_cmd_sched_if.sv
// Request/grant and memory command signals of the context command scheduler.
// Requests follow req/gnt semantics: a requester holds req (with its bank/len)
// high until it sees the one-cycle gnt; bank/len are sampled on the granting edge.
interface context_cmd_sched_if #(
  parameter int LEN_W = 6
);
  import ctx_mem_pkg::*;

  logic              wr_req;
  logic [BANK_W-1:0] wr_bank;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_gnt;
  logic              wr_done;
  logic              rd_req;
  logic [BANK_W-1:0] rd_bank;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_gnt;
  logic              rd_done;
  logic [7:0]        cmd;
  logic              context_en;
  logic              busy;
  state_t            dbg_state;

  modport master (
    output wr_req, wr_bank, wr_len, rd_req, rd_bank, rd_len,
    input  wr_gnt, wr_done, rd_gnt, rd_done, cmd, context_en, busy, dbg_state
  );

  modport slave (
    input  wr_req, wr_bank, wr_len, rd_req, rd_bank, rd_len,
    output wr_gnt, wr_done, rd_gnt, rd_done, cmd, context_en, busy, dbg_state
  );

endinterface

// File: rtl/context_cmd_sched.sv
// Arbitrates write and read burst requests into contiguous single-bank bursts
// on the context memory cmd bus, with a one-cycle bubble between bursts.
module context_cmd_sched
  import ctx_mem_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  context_cmd_sched_if.slave bus
);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             last_wr;
  logic             pick_wr;
  logic             pick_rd;

  // Round robin: on a tie the side that did not win last time goes first.
  always_comb begin
    pick_wr = bus.wr_req && (!bus.rd_req || !last_wr);
    pick_rd = bus.rd_req && !pick_wr;
  end

  assign bus.dbg_state = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      last_wr        <= 1'b0;
      bus.cmd        <= CMD_IDLE;
      bus.context_en <= 1'b0;
      bus.wr_gnt     <= 1'b0;
      bus.wr_done    <= 1'b0;
      bus.rd_gnt     <= 1'b0;
      bus.rd_done    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.wr_gnt  <= 1'b0;
      bus.rd_gnt  <= 1'b0;
      bus.wr_done <= 1'b0;
      bus.rd_done <= 1'b0;
      case (state)
        // The GAP cycle is itself the bubble; arbitrating at its end keeps the
        // spacing at exactly one idle cycle, and it falls back to IDLE otherwise.
        ST_IDLE, ST_GAP: begin
          if (pick_wr) begin
            state          <= ST_WR_BURST;
            cnt            <= bus.wr_len;
            last_wr        <= 1'b1;
            bus.cmd        <= wr_cmd(bus.wr_bank);
            bus.context_en <= 1'b1;
            bus.wr_gnt     <= 1'b1;
            bus.wr_done    <= (bus.wr_len == '0);
            bus.busy       <= 1'b1;
          end else if (pick_rd) begin
            state          <= ST_RD_BURST;
            cnt            <= bus.rd_len;
            last_wr        <= 1'b0;
            bus.cmd        <= rd_cmd(bus.rd_bank);
            bus.context_en <= 1'b1;
            bus.rd_gnt     <= 1'b1;
            bus.rd_done    <= (bus.rd_len == '0);
            bus.busy       <= 1'b1;
          end else begin
            state          <= ST_IDLE;
            bus.cmd        <= CMD_IDLE;
            bus.context_en <= 1'b0;
            bus.busy       <= 1'b0;
          end
        end
        // cnt holds the beats still to come after the one on the bus now.
        ST_WR_BURST, ST_RD_BURST: begin
          if (cnt == '0) begin
            state          <= ST_GAP;
            bus.cmd        <= CMD_IDLE;
            bus.context_en <= 1'b0;
            bus.busy       <= 1'b1;
          end else begin
            cnt         <= cnt - LEN_W'(1);
            bus.wr_done <= (state == ST_WR_BURST) && (cnt == LEN_W'(1));
            bus.rd_done <= (state == ST_RD_BURST) && (cnt == LEN_W'(1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_context_cmd_sched.sv
// Bench for context_cmd_sched: directed vector table, hand sequences for
// alternation, max-length and async reset, then random traffic vs a burst model.
module tb_context_cmd_sched;
  import ctx_mem_pkg::*;

  localparam int LEN_W = 6;
  localparam int REC_W = 14;
  // Record layout: [13:6] cmd, [5] context_en, [4] wr_gnt, [3] wr_done,
  // [2] rd_gnt, [1] rd_done, [0] busy.
  localparam logic [REC_W-1:0] REC_IDLE = {8'h80, 6'b000000};

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  context_cmd_sched_if #(.LEN_W(LEN_W)) bus ();
  context_cmd_sched #(.LEN_W(LEN_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] exp_cur;
  logic             model_last_wr;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;

  typedef struct {
    logic       wr_req;
    logic [1:0] wr_bank;
    logic [5:0] wr_len;
    logic       rd_req;
    logic [1:0] rd_bank;
    logic [5:0] rd_len;
    logic       exp_wr;
    logic [7:0] exp_cmd;
    int         exp_beats;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] dut_rec();
    return {bus.cmd, bus.context_en, bus.wr_gnt, bus.wr_done, bus.rd_gnt, bus.rd_done, bus.busy};
  endfunction

  // Reference: a granted request expands into len+1 beat records then one gap record.
  function automatic void push_burst(input logic is_wr, input logic [1:0] bank, input logic [5:0] len);
    logic [7:0] c;
    int beats;
    beats = int'(len) + 1;
    c = is_wr ? {1'b0, 1'b1, 1'b0, bank, 3'b000} : {1'b1, 4'b0000, 1'b0, bank};
    for (int i = 0; i < beats; i++) begin
      exp_q.push_back({c, 1'b1, is_wr && (i == 0), is_wr && (i == beats - 1),
                       !is_wr && (i == 0), !is_wr && (i == beats - 1), 1'b1});
    end
    exp_q.push_back({8'h80, 5'b00000, 1'b1});
  endfunction

  task automatic model_step();
    logic take_wr;
    if (exp_q.size() == 0 && (bus.wr_req || bus.rd_req)) begin
      if (bus.wr_req && bus.rd_req) take_wr = !model_last_wr;
      else take_wr = bus.wr_req;
      if (take_wr) push_burst(1'b1, bus.wr_bank, bus.wr_len);
      else push_burst(1'b0, bus.rd_bank, bus.rd_len);
      model_last_wr = take_wr;
    end
    exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : REC_IDLE;
  endtask

  task automatic cycle();
    model_step();
    @(posedge sys_clk);
    @(negedge sys_clk);
    cyc++;
    check("outputs", 32'(dut_rec()), 32'(exp_cur));
  endtask

  task automatic drop_granted();
    if (exp_cur[4]) bus.wr_req = 1'b0;
    if (exp_cur[2]) bus.rd_req = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((bus.wr_req || bus.rd_req || exp_q.size() > 0) && n < max_cyc) begin
      cycle();
      drop_granted();
      n++;
    end
    check("drain_timeout", 32'(bus.wr_req || bus.rd_req || exp_q.size() > 0), 32'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gnt_at, beats, done_beat, gnt_cnt;
    logic seen_gnt, seen_done, side_wr;
    logic [7:0] first_cmd;
    int gnt_cyc[$];
    logic gnt_side[$];

    vecs[0] = '{1'b1, 2'd2, 6'd3,  1'b0, 2'd0, 6'd0, 1'b1, 8'h50, 4};
    vecs[1] = '{1'b0, 2'd0, 6'd0,  1'b1, 2'd1, 6'd0, 1'b0, 8'h81, 1};
    vecs[2] = '{1'b1, 2'd0, 6'd1,  1'b1, 2'd3, 6'd1, 1'b1, 8'h40, 2};
    vecs[3] = '{1'b1, 2'd1, 6'd2,  1'b1, 2'd2, 6'd0, 1'b1, 8'h48, 3};
    vecs[4] = '{1'b1, 2'd3, 6'd63, 1'b0, 2'd0, 6'd0, 1'b1, 8'h58, 64};
    vecs[5] = '{1'b1, 2'd2, 6'd0,  1'b1, 2'd0, 6'd4, 1'b0, 8'h80, 5};
    vecs[6] = '{1'b0, 2'd0, 6'd0,  1'b1, 2'd3, 6'd5, 1'b0, 8'h83, 6};

    // Clock/reset
    sys_rst_n = 1'b0;
    bus.wr_req = 1'b0; bus.wr_bank = '0; bus.wr_len = '0;
    bus.rd_req = 1'b0; bus.rd_bank = '0; bus.rd_len = '0;
    exp_cur = REC_IDLE;
    model_last_wr = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", 32'(dut_rec()), 32'(REC_IDLE));
    check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    sys_rst_n = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 10; i++) cycle();
    check("idle_cmd", 32'(bus.cmd), 32'h80);
    check("idle_busy", 32'(bus.busy), 32'(0));

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      bus.wr_req = vecs[v].wr_req; bus.wr_bank = vecs[v].wr_bank; bus.wr_len = vecs[v].wr_len;
      bus.rd_req = vecs[v].rd_req; bus.rd_bank = vecs[v].rd_bank; bus.rd_len = vecs[v].rd_len;
      n = 0; gnt_at = 0; beats = 0; seen_gnt = 1'b0; seen_done = 1'b0;
      side_wr = 1'b0; first_cmd = '0;
      while (!seen_done && n < 100) begin
        cycle();
        n++;
        if (!seen_gnt && (bus.wr_gnt || bus.rd_gnt)) begin
          seen_gnt = 1'b1; gnt_at = n; side_wr = bus.wr_gnt; first_cmd = bus.cmd;
        end
        if (seen_gnt && bus.context_en) beats++;
        if (seen_gnt && (side_wr ? bus.wr_done : bus.rd_done)) seen_done = 1'b1;
        drop_granted();
      end
      check($sformatf("vec%0d_gnt_latency", v), 32'(gnt_at), 32'(1));
      check($sformatf("vec%0d_side_wr", v), 32'(side_wr), 32'(vecs[v].exp_wr));
      check($sformatf("vec%0d_cmd", v), 32'(first_cmd), 32'(vecs[v].exp_cmd));
      check($sformatf("vec%0d_beats", v), 32'(beats), 32'(vecs[v].exp_beats));
      drain(200);
    end

    // Both held continuously: W,R,W,R with one bubble between bursts
    bus.wr_req = 1'b1; bus.wr_bank = 2'd1; bus.wr_len = 6'd1;
    bus.rd_req = 1'b1; bus.rd_bank = 2'd2; bus.rd_len = 6'd1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (bus.wr_gnt || bus.rd_gnt) begin
        gnt_cyc.push_back(i);
        gnt_side.push_back(bus.wr_gnt);
      end
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    check("alt_grant_count", 32'(gnt_cyc.size()), 32'(4));
    for (int i = 0; i < gnt_cyc.size(); i++) begin
      check("alt_side", 32'(gnt_side[i]), 32'(i % 2 == 0));
      if (i > 0) check("alt_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'(3));
    end
    drain(20);

    // Max length; request stays up then drops mid-burst, len wiggles
    bus.wr_req = 1'b1; bus.wr_bank = 2'd3; bus.wr_len = 6'h3F;
    n = 0; beats = 0; done_beat = 0; gnt_cnt = 0;
    while (done_beat == 0 && n < 120) begin
      cycle();
      n++;
      if (bus.wr_gnt) gnt_cnt++;
      if (bus.context_en) beats++;
      if (bus.wr_done) done_beat = beats;
      if (beats == 30) bus.wr_req = 1'b0;
      bus.wr_len = 6'($urandom_range(0, 63));
      bus.wr_bank = 2'($urandom_range(0, 3));
    end
    bus.wr_req = 1'b0;
    check("max_done_beat", 32'(done_beat), 32'(64));
    check("max_beats", 32'(beats), 32'(64));
    check("max_grants", 32'(gnt_cnt), 32'(1));
    drain(20);

    // Async reset at beat 5 of a read burst
    bus.rd_req = 1'b1; bus.rd_bank = 2'd1; bus.rd_len = 6'd9;
    n = 0; beats = 0;
    while (beats < 5 && n < 20) begin
      cycle();
      n++;
      if (bus.context_en) beats++;
      drop_granted();
    end
    check("rst_reached_beat5", 32'(beats), 32'(5));
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'(dut_rec()), 32'(REC_IDLE));
    check("rst_async_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    model_last_wr = 1'b0;
    exp_cur = REC_IDLE;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_held_outputs", 32'(dut_rec()), 32'(REC_IDLE));
    sys_rst_n = 1'b1;
    cycle();
    check("rst_no_done", 32'(bus.rd_done), 32'(0));
    bus.wr_req = 1'b1; bus.wr_bank = 2'd0; bus.wr_len = 6'd0;
    bus.rd_req = 1'b1; bus.rd_bank = 2'd2; bus.rd_len = 6'd0;
    cycle();
    check("rst_tie_wr_gnt", 32'(bus.wr_gnt), 32'(1));
    check("rst_tie_rd_gnt", 32'(bus.rd_gnt), 32'(0));
    drop_granted();
    drain(20);

    // Random traffic against the burst model
    for (int i = 0; i < 600; i++) begin
      if (!bus.wr_req && $urandom_range(0, 3) == 0) bus.wr_req = 1'b1;
      if (!bus.rd_req && $urandom_range(0, 3) == 0) bus.rd_req = 1'b1;
      bus.wr_bank = 2'($urandom_range(0, 3));
      bus.rd_bank = 2'($urandom_range(0, 3));
      bus.wr_len = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
      bus.rd_len = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
      cycle();
      drop_granted();
    end
    drain(300);
    for (int i = 0; i < 3; i++) cycle();
    check("final_idle", 32'(dut_rec()), 32'(REC_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
